// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: a Moore FSM that sequences the shared memory
// port, ALU and register file, with a memory-ready handshake in FETCH/MEMREAD/MEMWRITE.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       InstrDone,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t state_q, state_d;

  logic       alu_f3_ok;
  logic [3:0] alu_funct;
  logic       pc_wr, ir_wr, mem_wr, reg_wr, done;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    alu_f3_ok = 1'b1;
    alu_funct = 4'b0000;
    case (funct3)
      3'b000:  alu_funct = (op[5] & funct7b5) ? 4'b0001 : 4'b0000;
      3'b010:  alu_funct = 4'b0101;
      3'b110:  alu_funct = 4'b0011;
      3'b111:  alu_funct = 4'b0010;
      default: alu_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    done       = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 4'b0000;
    Illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LW, OP_SW: state_d = (funct3 == 3'b010) ? S_MEMADR : S_ERROR;
          OP_R:         state_d = alu_f3_ok ? S_EXECR : S_ERROR;
          OP_I:         state_d = alu_f3_ok ? S_EXECI : S_ERROR;
          OP_BR:        state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALRADR;
          OP_LUI:       state_d = S_LUI;
          OP_AUIPC:     state_d = S_AUIPC;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'b001 : 3'b000;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        if (MemReady) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr  = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 4'b0001;
        pc_wr      = Zero ^ funct3[0];
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL, S_JALR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_wr   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR;
      end
      S_LUI: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b100;
        ALUControl = 4'b1011;
        state_d    = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
        state_d = S_ALUWB;
      end
      default: Illegal = 1'b1;
    endcase
  end

  // Reset gates every write so an abandoned instruction commits nothing.
  assign PCWrite   = pc_wr  & ~reset;
  assign IRWrite   = ir_wr  & ~reset;
  assign MemWrite  = mem_wr & ~reset;
  assign RegWrite  = reg_wr & ~reset;
  assign InstrDone = done   & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Directed per-cycle vector bench for mc_controller: each record gives the
// inputs for one clock cycle and the full expected output word for that cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                         BAD = 7'b1111111;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,InstrDone,Illegal}
  function automatic logic [19:0] ex(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, sa, sb,
                                     input logic [2:0] imm, input logic [3:0] alu,
                                     input logic id, ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, id, ill};
  endfunction

  function automatic logic [19:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, ALUControl, InstrDone, Illegal};
  endfunction

  task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, z, mr, input logic [19:0] e, input string n);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr;
    v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [19:0] a;
    @(negedge clk);
    reset = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; MemReady = v.mr;
    #1;
    a = actual();
    checks++;
    if (a !== v.exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", v.name, a, v.exp);
    end
  endtask

  initial begin
    logic [19:0] f_rdy, f_wait, f_rst, dec, dec_j, aluwb, memadr_l, memadr_s,
                 memrd, memwb, memwr, memwr_done, jmp, err, zero_out;
    vec_t v;

    f_rdy      = ex(1,0,0,1,0, 2'b10,2'b00,2'b10, 3'b000,4'b0000, 0,0);
    f_wait     = ex(0,0,0,0,0, 2'b10,2'b00,2'b10, 3'b000,4'b0000, 0,0);
    f_rst      = f_wait;
    dec        = ex(0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b010,4'b0000, 0,0);
    dec_j      = ex(0,0,0,0,0, 2'b00,2'b01,2'b01, 3'b011,4'b0000, 0,0);
    aluwb      = ex(0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 1,0);
    memadr_l   = ex(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b000,4'b0000, 0,0);
    memadr_s   = ex(0,0,0,0,0, 2'b00,2'b10,2'b01, 3'b001,4'b0000, 0,0);
    memrd      = ex(0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 0,0);
    memwb      = ex(0,0,0,0,1, 2'b01,2'b00,2'b00, 3'b000,4'b0000, 1,0);
    memwr      = ex(0,1,1,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 0,0);
    memwr_done = ex(0,1,1,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 1,0);
    jmp        = ex(1,0,0,0,0, 2'b00,2'b01,2'b10, 3'b000,4'b0000, 0,0);
    err        = ex(0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 0,1);
    zero_out   = ex(0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000,4'b0000, 0,0);

    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) @(posedge clk);

    // Reset: held in FETCH with MemReady=1, enables stay low
    add(1, RT,3'b000,0,0,1, f_rst, "reset_fetch");
    // R-type sub
    add(0, RT,3'b000,1,0,1, f_rdy, "sub_fetch");
    add(0, RT,3'b000,1,0,1, dec, "sub_decode");
    add(0, RT,3'b000,1,0,1, ex(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,0,0), "sub_execr");
    add(0, RT,3'b000,1,0,1, aluwb, "sub_aluwb");
    // R-type or, funct7b5 ignored off funct3=000
    add(0, RT,3'b110,1,0,1, f_rdy, "or_fetch");
    add(0, RT,3'b110,1,0,1, dec, "or_decode");
    add(0, RT,3'b110,1,0,1, ex(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0011,0,0), "or_execr");
    add(0, RT,3'b110,1,0,1, aluwb, "or_aluwb");
    // addi with funct7b5=1 still adds (op[5]=0)
    add(0, IA,3'b000,1,0,1, f_rdy, "addi_fetch");
    add(0, IA,3'b000,1,0,1, dec, "addi_decode");
    add(0, IA,3'b000,1,0,1, ex(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0000,0,0), "addi_execi");
    add(0, IA,3'b000,1,0,1, aluwb, "addi_aluwb");
    // slti and andi
    add(0, IA,3'b010,0,0,1, f_rdy, "slti_fetch");
    add(0, IA,3'b010,0,0,1, dec, "slti_decode");
    add(0, IA,3'b010,0,0,1, ex(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0101,0,0), "slti_execi");
    add(0, IA,3'b010,0,0,1, aluwb, "slti_aluwb");
    add(0, IA,3'b111,0,0,1, f_rdy, "andi_fetch");
    add(0, IA,3'b111,0,0,1, dec, "andi_decode");
    add(0, IA,3'b111,0,0,1, ex(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'b0010,0,0), "andi_execi");
    add(0, IA,3'b111,0,0,1, aluwb, "andi_aluwb");
    // lw: 2 fetch waits, 3 memread waits, 10 cycles total
    add(0, LW,3'b010,0,0,0, f_wait, "lw_fetch_wait0");
    add(0, LW,3'b010,0,0,0, f_wait, "lw_fetch_wait1");
    add(0, LW,3'b010,0,0,1, f_rdy, "lw_fetch");
    add(0, LW,3'b010,0,0,0, dec, "lw_decode_mr_ignored");
    add(0, LW,3'b010,0,0,1, memadr_l, "lw_memadr");
    add(0, LW,3'b010,0,0,0, memrd, "lw_memread_wait0");
    add(0, LW,3'b010,0,0,0, memrd, "lw_memread_wait1");
    add(0, LW,3'b010,0,0,0, memrd, "lw_memread_wait2");
    add(0, LW,3'b010,0,0,1, memrd, "lw_memread");
    add(0, LW,3'b010,0,0,1, memwb, "lw_memwb");
    // sw: MemWrite held through 2 wait cycles
    add(0, SW,3'b010,0,0,1, f_rdy, "sw_fetch");
    add(0, SW,3'b010,0,0,1, dec, "sw_decode");
    add(0, SW,3'b010,0,0,1, memadr_s, "sw_memadr");
    add(0, SW,3'b010,0,0,0, memwr, "sw_memwrite_wait0");
    add(0, SW,3'b010,0,0,0, memwr, "sw_memwrite_wait1");
    add(0, SW,3'b010,0,0,1, memwr_done, "sw_memwrite_done");
    // branches
    add(0, BR,3'b000,0,0,1, f_rdy, "beq1_fetch");
    add(0, BR,3'b000,0,0,1, dec, "beq1_decode");
    add(0, BR,3'b000,0,1,1, ex(1,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,1,0), "beq_taken");
    add(0, BR,3'b000,0,1,1, f_rdy, "beq0_fetch");
    add(0, BR,3'b000,0,1,1, dec, "beq0_decode");
    add(0, BR,3'b000,0,0,1, ex(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,1,0), "beq_not_taken");
    add(0, BR,3'b001,0,0,1, f_rdy, "bne_fetch");
    add(0, BR,3'b001,0,0,1, dec, "bne_decode");
    add(0, BR,3'b001,0,0,1, ex(1,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,1,0), "bne_taken");
    add(0, BR,3'b001,0,1,1, f_rdy, "bne1_fetch");
    add(0, BR,3'b001,0,1,1, dec, "bne1_decode");
    add(0, BR,3'b001,0,1,1, ex(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0001,1,0), "bne_not_taken");
    // jal
    add(0, JL,3'b000,0,0,1, f_rdy, "jal_fetch");
    add(0, JL,3'b000,0,0,1, dec_j, "jal_decode");
    add(0, JL,3'b000,0,0,1, jmp, "jal_jal");
    add(0, JL,3'b000,0,0,1, aluwb, "jal_aluwb");
    // jalr
    add(0, JR,3'b000,0,0,1, f_rdy, "jalr_fetch");
    add(0, JR,3'b000,0,0,1, dec, "jalr_decode");
    add(0, JR,3'b000,0,0,1, memadr_l, "jalr_jalradr");
    add(0, JR,3'b000,0,0,1, jmp, "jalr_jalr");
    add(0, JR,3'b000,0,0,1, aluwb, "jalr_aluwb");
    // lui / auipc
    add(0, LU,3'b000,0,0,1, f_rdy, "lui_fetch");
    add(0, LU,3'b000,0,0,1, dec, "lui_decode");
    add(0, LU,3'b000,0,0,1, ex(0,0,0,0,0,2'b00,2'b00,2'b01,3'b100,4'b1011,0,0), "lui_lui");
    add(0, LU,3'b000,0,0,1, aluwb, "lui_aluwb");
    add(0, AU,3'b000,0,0,1, f_rdy, "auipc_fetch");
    add(0, AU,3'b000,0,0,1, dec, "auipc_decode");
    add(0, AU,3'b000,0,0,1, ex(0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,4'b0000,0,0), "auipc_auipc");
    add(0, AU,3'b000,0,0,1, aluwb, "auipc_aluwb");
    // lw with bad funct3 traps, reset recovers
    add(0, LW,3'b000,0,0,1, f_rdy, "badlw_fetch");
    add(0, LW,3'b000,0,0,1, dec, "badlw_decode");
    add(0, LW,3'b000,0,0,1, err, "badlw_error");
    add(1, LW,3'b000,0,0,1, err, "badlw_error_in_reset");
    // R-type funct3=001 traps
    add(0, RT,3'b001,0,0,1, f_rdy, "badr_fetch");
    add(0, RT,3'b001,0,0,1, dec, "badr_decode");
    add(0, RT,3'b001,0,0,1, err, "badr_error");
    add(1, RT,3'b001,0,0,1, err, "badr_error_in_reset");
    // branch funct3=100 traps
    add(0, BR,3'b100,0,0,1, f_rdy, "badbr_fetch");
    add(0, BR,3'b100,0,0,1, dec, "badbr_decode");
    add(0, BR,3'b100,0,0,1, err, "badbr_error");
    add(1, BR,3'b100,0,0,1, err, "badbr_error_in_reset");
    // reset mid-lw in MEMREAD: no RegWrite, back to FETCH
    add(0, LW,3'b010,0,0,1, f_rdy, "rstlw_fetch");
    add(0, LW,3'b010,0,0,1, dec, "rstlw_decode");
    add(0, LW,3'b010,0,0,1, memadr_l, "rstlw_memadr");
    add(1, LW,3'b010,0,0,1, memrd, "rstlw_memread_in_reset");
    add(0, LW,3'b010,0,0,1, f_rdy, "rstlw_back_to_fetch");
    // reset mid-sw in MEMWRITE forces MemWrite and InstrDone low
    add(0, LW,3'b010,0,0,1, dec, "rstsw_decode_lw");
    add(0, SW,3'b010,0,0,1, memadr_s, "rstsw_memadr");
    add(1, SW,3'b010,0,0,1, ex(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0,0), "rstsw_memwrite_in_reset");
    add(0, SW,3'b010,0,0,0, f_wait, "rstsw_back_to_fetch");

    foreach (tbl[i]) apply(tbl[i]);

    // Illegal opcode: ERROR held 20 cycles with all inputs toggling
    v.rst = 0; v.op = BAD; v.f3 = 3'b000; v.f7 = 0; v.z = 0; v.mr = 1;
    v.exp = f_rdy; v.name = "badop_fetch"; apply(v);
    v.exp = dec; v.name = "badop_decode"; apply(v);
    for (int k = 0; k < 20; k++) begin
      v.op = (k % 2 == 0) ? BAD : RT;
      v.z = k[0]; v.mr = k[1]; v.f3 = k[2:0]; v.f7 = k[3];
      v.exp = err; v.name = $sformatf("badop_error_%0d", k);
      apply(v);
    end
    v.rst = 1; v.exp = err; v.name = "badop_error_in_reset"; apply(v);
    v.rst = 0; v.op = RT; v.f3 = 3'b000; v.mr = 0;
    v.exp = f_wait; v.name = "badop_recovered_fetch"; apply(v);
    v.mr = 1; v.exp = f_rdy; v.name = "badop_recovered_fetch_rdy"; apply(v);
    v.exp = dec; v.name = "badop_recovered_decode"; apply(v);
    v.exp = zero_out | ex(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'b0000,0,0);
    v.name = "badop_recovered_execr_add"; apply(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
